cpu_controller: RTL and testbench
=================================

CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 SHALL have parameter: MEM_WAIT, default 0, extra wait cycles (0..7) held in each memory-fetch phase.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: opcode  input  3  instruction opcode from the instruction register (HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111).
REQ-005 SHALL have port: zero  input  1  accumulator-is-zero flag from the ALU (a_is_zero).
REQ-006 SHALL have ports, each output 1 bit: sel (address mux: PC), rd (memory read), ld_ir (load IR), inc_pc (increment PC), ld_pc (load PC), ld_ac (load accumulator), wr (memory write), data_e (drive data bus), halt.
REQ-007 SHALL have port: phase  output  3  current phase index (0..7).

Function
REQ-008 SHALL sequence eight phases in order, then wrap 7->0: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
REQ-009 SHALL hold INST_FETCH and OP_FETCH for 1+MEM_WAIT cycles each, using a wait counter cleared on entry; other phases last exactly 1 cycle.
REQ-010 SHALL make an instruction cycle 8+2*MEM_WAIT clocks long.
REQ-011 SHALL compute ALUOP = opcode in {ADD, AND, XOR, LDA}.
REQ-012 SHALL decode outputs combinationally from the registered phase, opcode and zero (Moore on phase, Mealy on zero in ALU_OP only).
REQ-013 SHALL, in INST_ADDR, drive sel=1 only.
REQ-014 SHALL, in INST_FETCH, drive sel=1 and rd=1 on every wait cycle.
REQ-015 SHALL, in INST_LOAD and IDLE, drive sel=1, rd=1 and ld_ir=1.
REQ-016 SHALL, in OP_ADDR, drive inc_pc=1, and halt=1 when opcode=HLT.
REQ-017 SHALL, in OP_FETCH, drive rd=ALUOP on every wait cycle.
REQ-018 SHALL, in ALU_OP, drive rd=ALUOP, inc_pc=(opcode==SKZ && zero), ld_pc=(opcode==JMP) and data_e=(opcode==STO).
REQ-019 SHALL, in STORE, drive rd=ALUOP, ld_ac=ALUOP, ld_pc=(opcode==JMP), wr=(opcode==STO) and data_e=(opcode==STO).
REQ-020 SHALL drive every output not listed for a phase to 0.
REQ-021 SHALL, on a clock edge in OP_ADDR with opcode=HLT, enter a HALTED state: phase frozen at 4, halt=1, all other outputs 0, no further advance.
REQ-022 SHALL leave HALTED only on rst.
REQ-023 SHALL ignore opcode changes outside OP_ADDR..STORE except for output decode; opcode SHALL affect neither sequencing nor counters, except the HLT entry of REQ-021.
REQ-024 SHALL never assert wr and rd in the same cycle.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, set phase=0, clear the wait counter and HALTED; this has priority over all other transitions, including mid-wait and HALTED.
REQ-026 SHALL, in the cycle after reset, present sel=1 and all other outputs 0, halt=0.
REQ-027 SHALL resume normal sequencing on the first edge with rst=0 (phase 0->1).

Verification
REQ-028 SHALL be verified with MEM_WAIT=0, opcode=ADD: phases run 0..7 over 8 clocks; rd=1 in phases 1,2,3,5,6,7; ld_ac=1 only in phase 7; next cycle phase=0.
REQ-029 SHALL be verified with opcode=SKZ: zero=1 gives inc_pc=1 in phases 4 and 6; zero=0 gives inc_pc=1 in phase 4 only; ld_ac never asserts.
REQ-030 SHALL be verified with opcode=STO: data_e=1 in phases 6 and 7; wr=1 only in phase 7; rd=0 in phases 5-7.
REQ-031 SHALL be verified with opcode=JMP: ld_pc=1 in phases 6 and 7; opcode=HLT: halt=1 in phase 4, then HALTED for 20+ clocks with phase=4, halt=1 and other outputs 0 until rst.
REQ-032 SHALL be verified with MEM_WAIT=3, opcode=LDA: phase 1 and phase 5 each held 4 cycles with rd=1; full cycle 14 clocks.
REQ-033 SHALL be verified with rst asserted mid-wait in phase 5: next cycle phase=0, sel=1, other outputs 0; the following instruction timing matches REQ-032.

Source files
------------

// File: rtl/cpu_controller.sv
// -----------------------------------------------------------------------------
// cpu_controller
//
// Phase sequencer and control decoder for a simple accumulator CPU. One
// instruction cycle walks eight phases (instruction address/fetch/load, idle,
// operand address/fetch, ALU op, store). The two memory-fetch phases can be
// stretched by MEM_WAIT extra cycles to cover slow memory. An HLT opcode seen
// at the operand-address edge freezes the controller until reset.
//
// Parameters
//   MEM_WAIT  extra wait cycles (0..7) held in INST_FETCH and OP_FETCH
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset
//   opcode  in   [2:0] opcode from the instruction register
//   zero    in   accumulator-is-zero flag from the ALU
//   sel     out  address mux selects the PC
//   rd      out  memory read
//   ld_ir   out  load instruction register
//   inc_pc  out  increment PC
//   ld_pc   out  load PC
//   ld_ac   out  load accumulator
//   wr      out  memory write
//   data_e  out  drive data bus
//   halt    out  processor halted / halting
//   phase   out  [2:0] current phase index
// -----------------------------------------------------------------------------
module cpu_controller #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    StInstAddr  = 3'd0,
    StInstFetch = 3'd1,
    StInstLoad  = 3'd2,
    StIdle      = 3'd3,
    StOpAddr    = 3'd4,
    StOpFetch   = 3'd5,
    StAluOp     = 3'd6,
    StStore     = 3'd7
  } phase_e;

  localparam logic [2:0] OpHlt = 3'b000;
  localparam logic [2:0] OpSkz = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpAnd = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpLda = 3'b101;
  localparam logic [2:0] OpSto = 3'b110;
  localparam logic [2:0] OpJmp = 3'b111;

  localparam logic [2:0] WaitMax = 3'(MEM_WAIT);

  phase_e     phase_q, phase_d;
  logic [2:0] wait_q, wait_d;
  logic       halted_q, halted_d;
  logic       alu_op;

  // Opcodes that read an operand from memory and write the accumulator.
  assign alu_op = (opcode == OpAdd) || (opcode == OpAnd) ||
                  (opcode == OpXor) || (opcode == OpLda);

  // State register; reset wins over everything, including HALTED and mid-wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= StInstAddr;
      wait_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      wait_q   <= wait_d;
      halted_q <= halted_d;
    end
  end

  // Next-state: opcode only matters for HLT entry at OP_ADDR.
  always_comb begin
    phase_d  = phase_q;
    wait_d   = wait_q;
    halted_d = halted_q;
    if (!halted_q) begin
      case (phase_q)
        StOpAddr: begin
          if (opcode == OpHlt) begin
            halted_d = 1'b1;
          end else begin
            phase_d = StOpFetch;
            wait_d  = '0;
          end
        end
        StInstFetch, StOpFetch: begin
          if (wait_q < WaitMax) begin
            wait_d = wait_q + 3'd1;
          end else begin
            wait_d  = '0;
            phase_d = phase_e'(phase_q + 3'd1);
          end
        end
        default: begin
          // Wait counter cleared so the next fetch phase starts from zero.
          wait_d  = '0;
          phase_d = phase_e'(phase_q + 3'd1);
        end
      endcase
    end
  end

  // Output decode: Moore on phase, Mealy on zero only in ALU_OP.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (phase_q)
        StInstAddr: begin
          sel = 1'b1;
        end
        StInstFetch: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        StInstLoad, StIdle: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        StOpAddr: begin
          inc_pc = 1'b1;
          halt   = (opcode == OpHlt);
        end
        StOpFetch: begin
          rd = alu_op;
        end
        StAluOp: begin
          rd     = alu_op;
          inc_pc = (opcode == OpSkz) && zero;
          ld_pc  = (opcode == OpJmp);
          data_e = (opcode == OpSto);
        end
        StStore: begin
          // rd is only set for ALU ops, wr only for STO, so they never overlap.
          rd     = alu_op;
          ld_ac  = alu_op;
          ld_pc  = (opcode == OpJmp);
          wr     = (opcode == OpSto);
          data_e = (opcode == OpSto);
        end
        default: begin
        end
      endcase
    end
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_cpu_controller.sv
// -----------------------------------------------------------------------------
// tb_cpu_controller
//
// Drives two controllers (MEM_WAIT=0 and MEM_WAIT=3) from shared inputs.
// Expected outputs come from per-opcode tables of phase masks (bit p of each
// mask = output level in phase p); expectations are queued as stimulus is
// applied and popped when the DUT output is sampled. Hand-written sequences
// cover HLT entry, reset out of HALTED and reset mid-wait.
// -----------------------------------------------------------------------------
module tb_cpu_controller;

  localparam logic [2:0] OpHlt = 3'b000;
  localparam logic [2:0] OpSkz = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpAnd = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpLda = 3'b101;
  localparam logic [2:0] OpSto = 3'b110;
  localparam logic [2:0] OpJmp = 3'b111;

  typedef struct {
    logic [2:0] op;
    logic       z;
    logic [7:0] sel_m;
    logic [7:0] rd_m;
    logic [7:0] ir_m;
    logic [7:0] inc_m;
    logic [7:0] ldpc_m;
    logic [7:0] ldac_m;
    logic [7:0] wr_m;
    logic [7:0] de_m;
    logic [7:0] hlt_m;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;

  logic       sel0, rd0, ld_ir0, inc_pc0, ld_pc0, ld_ac0, wr0, data_e0, halt0;
  logic       sel3, rd3, ld_ir3, inc_pc3, ld_pc3, ld_ac3, wr3, data_e3, halt3;
  logic [2:0] phase0, phase3;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q[$];
  vec_t        tbl[9];
  vec_t        hlt_rec;

  // Packed view: {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
  logic [11:0] obs0, obs3;
  assign obs0 = {phase0, sel0, rd0, ld_ir0, inc_pc0, ld_pc0, ld_ac0, wr0, data_e0, halt0};
  assign obs3 = {phase3, sel3, rd3, ld_ir3, inc_pc3, ld_pc3, ld_ac3, wr3, data_e3, halt3};

  always #5 clk = ~clk;

  cpu_controller #(.MEM_WAIT(0)) dut0 (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel0),
    .rd     (rd0),
    .ld_ir  (ld_ir0),
    .inc_pc (inc_pc0),
    .ld_pc  (ld_pc0),
    .ld_ac  (ld_ac0),
    .wr     (wr0),
    .data_e (data_e0),
    .halt   (halt0),
    .phase  (phase0)
  );

  cpu_controller #(.MEM_WAIT(3)) dut3 (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel3),
    .rd     (rd3),
    .ld_ir  (ld_ir3),
    .inc_pc (inc_pc3),
    .ld_pc  (ld_pc3),
    .ld_ac  (ld_ac3),
    .wr     (wr3),
    .data_e (data_e3),
    .halt   (halt3),
    .phase  (phase3)
  );

  function automatic vec_t mk(input logic [2:0] op, input logic z, input logic [7:0] s,
                              input logic [7:0] r, input logic [7:0] ir, input logic [7:0] inc,
                              input logic [7:0] ldpc, input logic [7:0] ldac,
                              input logic [7:0] w, input logic [7:0] de, input logic [7:0] h,
                              input string nm);
    vec_t v;
    v.op = op; v.z = z; v.sel_m = s; v.rd_m = r; v.ir_m = ir; v.inc_m = inc;
    v.ldpc_m = ldpc; v.ldac_m = ldac; v.wr_m = w; v.de_m = de; v.hlt_m = h; v.name = nm;
    return v;
  endfunction

  function automatic logic [11:0] exp_out(input vec_t r, input int p);
    return {3'(p), r.sel_m[p], r.rd_m[p], r.ir_m[p], r.inc_m[p], r.ldpc_m[p],
            r.ldac_m[p], r.wr_m[p], r.de_m[p], r.hlt_m[p]};
  endfunction

  // Sample shortly after inputs settle; pop the queued expectation and compare.
  task automatic check(input int d, input logic [11:0] e, input string nm);
    logic [11:0] obs;
    logic [11:0] want;
    exp_q.push_back(e);
    #2;
    obs  = (d == 3) ? obs3 : obs0;
    want = exp_q.pop_front();
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s dut%0d: got %03h want %03h (phase,sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt)",
               nm, d, obs, want);
    end
    checks++;
    if (obs[7] && obs[2]) begin
      errors++;
      $display("FAIL %s dut%0d rd_wr_excl: got rd=1 wr=1 want not both", nm, d);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Check the first n cycles of an instruction with w wait cycles per fetch phase.
  task automatic run_inst(input int d, input vec_t r, input int w, input int n);
    int k;
    k = 0;
    opcode = r.op;
    zero   = r.z;
    for (int p = 0; p < 8; p++) begin
      int reps;
      reps = (p == 1 || p == 5) ? 1 + w : 1;
      for (int j = 0; j < reps; j++) begin
        if (k < n) begin
          check(d, exp_out(r, p), r.name);
          tick();
        end
        k++;
      end
    end
  endtask

  initial begin
    tbl[0] = mk(OpAdd, 1'b0, 8'h0F, 8'hEE, 8'h0C, 8'h10, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, "add_z0");
    tbl[1] = mk(OpAdd, 1'b1, 8'h0F, 8'hEE, 8'h0C, 8'h10, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, "add_z1");
    tbl[2] = mk(OpAnd, 1'b0, 8'h0F, 8'hEE, 8'h0C, 8'h10, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, "and");
    tbl[3] = mk(OpXor, 1'b1, 8'h0F, 8'hEE, 8'h0C, 8'h10, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, "xor");
    tbl[4] = mk(OpLda, 1'b0, 8'h0F, 8'hEE, 8'h0C, 8'h10, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, "lda");
    tbl[5] = mk(OpSkz, 1'b1, 8'h0F, 8'h0E, 8'h0C, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, "skz_z1");
    tbl[6] = mk(OpSkz, 1'b0, 8'h0F, 8'h0E, 8'h0C, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, "skz_z0");
    tbl[7] = mk(OpSto, 1'b0, 8'h0F, 8'h0E, 8'h0C, 8'h10, 8'h00, 8'h00, 8'h80, 8'hC0, 8'h00, "sto");
    tbl[8] = mk(OpJmp, 1'b1, 8'h0F, 8'h0E, 8'h0C, 8'h10, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, "jmp");
    hlt_rec = mk(OpHlt, 1'b0, 8'h0F, 8'h0E, 8'h0C, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10,
                 "hlt");

    rst    = 1'b1;
    opcode = OpAdd;
    zero   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check(0, 12'h100, "reset_state");
    check(3, 12'h100, "reset_state");

    // Back-to-back instructions on MEM_WAIT=0, wrapping 7 -> 0 between them.
    for (int i = 0; i < 9; i++) begin
      run_inst(0, tbl[i], 0, 8);
    end
    opcode = OpAdd;
    check(0, 12'h100, "wrap_to_0");

    // HLT: normal through phase 4, then frozen until reset.
    do_reset();
    run_inst(0, hlt_rec, 0, 5);
    for (int i = 0; i < 22; i++) begin
      opcode = (i < 11) ? OpHlt : OpAdd;
      zero   = i[0];
      check(0, {3'd4, 9'b0_0000_0001}, "halted");
      tick();
    end
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    opcode = OpAdd;
    zero   = 1'b0;
    check(0, 12'h100, "reset_from_halt");
    tick();
    check(0, exp_out(tbl[0], 1), "resume_ph1");

    // MEM_WAIT=3: 14-clock instruction, fetch phases held 4 cycles.
    do_reset();
    run_inst(3, tbl[4], 3, 14);
    check(3, 12'h100, "w3_wrap");
    run_inst(3, tbl[5], 3, 14);
    check(3, 12'h100, "w3_wrap_skz");

    // Reset on the second wait cycle of OP_FETCH.
    do_reset();
    run_inst(3, tbl[4], 3, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check(3, 12'h100, "reset_mid_wait");
    run_inst(3, tbl[4], 3, 14);
    check(3, 12'h100, "after_mid_wait");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
